// File: rtl/fir_out_requant.sv
// Requantises 32-bit FIR sums to 16 bits (round half-up, saturate), decimates, and buffers kept samples.
// Latency: a kept sample is on out_data/out_valid two clocks after the edge that accepts it.
// Backpressure: out_ready stalls only the FIFO; when full, a kept sample is dropped and drop_sticky latches.
module fir_out_requant #(
  parameter int SHIFT = 8,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic signed [31:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [15:0]         out_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       sat_pulse,
  output logic                       drop_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

  logic [PW-1:0]        phase_q, phase_d;
  logic                 keep_w;
  logic signed [32:0]   t_w, r_w;
  logic signed [15:0]   q_w;
  logic                 clip_w;

  logic                 s1_vld_q;
  logic signed [15:0]   s1_dat_q;
  logic                 sat_q;

  logic signed [15:0]   mem_q [DEPTH];
  logic [LW-1:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]        level_w;
  logic                 pop_w, full_w, wr_en_w, drop_w;
  logic                 out_vld_q, out_vld_d;
  logic signed [15:0]   out_dat_q;
  logic                 drop_q;

  // Round half toward +inf in a 33-bit intermediate so 0x7FFFFFFF cannot wrap, then clip to 16 bits.
  always_comb begin
    t_w    = {in_data[31], in_data} + RND;
    r_w    = t_w >>> SHIFT;
    q_w    = r_w[15:0];
    clip_w = 1'b0;
    if (r_w > 33'sd32767) begin
      q_w    = 16'sh7fff;
      clip_w = 1'b1;
    end else if (r_w < -33'sd32768) begin
      q_w    = -16'sh8000;
      clip_w = 1'b1;
    end
  end

  // Decimation phase advances on every input strobe; only phase 0 samples are kept.
  always_comb begin
    keep_w  = in_valid && (phase_q == '0);
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end
  end

  // Stage 1 register: never stalls, loads only kept samples, flags clipping for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      sat_q    <= 1'b0;
    end else if (clr) begin
      phase_q  <= '0;
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      s1_vld_q <= keep_w;
      sat_q    <= keep_w && clip_w;
      if (keep_w) s1_dat_q <= q_w;
    end
  end

  // FIFO control: a full write is accepted only if the head leaves in the same cycle. The output
  // register looks at the write count from before this edge, so a write shows up one clock later.
  always_comb begin
    level_w   = wr_cnt_q - rd_cnt_q;
    pop_w     = out_vld_q && out_ready;
    full_w    = (level_w == LW'(DEPTH));
    wr_en_w   = s1_vld_q && (!full_w || pop_w);
    drop_w    = s1_vld_q && full_w && !pop_w;
    wr_cnt_d  = wr_cnt_q + (wr_en_w ? LW'(1) : LW'(0));
    rd_cnt_d  = rd_cnt_q + (pop_w ? LW'(1) : LW'(0));
    out_vld_d = ((wr_cnt_q - rd_cnt_d) != '0);
  end

  // Storage array has no reset; the counters define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en_w && !clr) mem_q[wr_cnt_q[AW-1:0]] <= s1_dat_q;
  end

  // Pointer, registered head and sticky drop state; out_data keeps its last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      drop_q    <= 1'b0;
    end else if (clr) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_vld_q <= out_vld_d;
      if (out_vld_d) out_dat_q <= mem_q[rd_cnt_d[AW-1:0]];
      if (drop_w) drop_q <= 1'b1;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_data    = out_dat_q;
  assign fifo_level  = level_w;
  assign sat_pulse   = sat_q;
  assign drop_sticky = drop_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: one instance at DECIM=1 and one at DECIM=4, both SHIFT=8, DEPTH=4.
// Rounding/saturation from a vector table; decimation, full FIFO, clr and reset as directed sequences.
module tb_fir_out_requant;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, clr, in_valid, out_ready1, out_ready4;
  logic signed [31:0] in_data;
  logic               v1, v4, sat1, sat4, drop1, drop4;
  logic signed [15:0] d1, d4;
  logic [2:0]         lvl1, lvl4;

  fir_out_requant #(.SHIFT(8), .DECIM(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready1), .out_data(d1), .fifo_level(lvl1),
    .sat_pulse(sat1), .drop_sticky(drop1));

  fir_out_requant #(.SHIFT(8), .DECIM(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v4), .out_ready(out_ready4), .out_data(d4), .fifo_level(lvl4),
    .sat_pulse(sat4), .drop_sticky(drop4));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [31:0] din;
    int                 exp_q;
    logic               exp_sat;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_in(input logic signed [31:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Wait (bounded) for the head of the selected instance, compare it, then pop it.
  task automatic pop_chk(input bit sel4, input string name, input int exp);
    int n = 0;
    while (!(sel4 ? v4 : v1) && n < 20) begin
      tick();
      n++;
    end
    chk({name, " valid"}, sel4 ? 32'(v4) : 32'(v1), 1);
    chk(name, sel4 ? 32'($signed(d4)) : 32'($signed(d1)), exp);
    if (sel4) out_ready4 = 1'b1; else out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic sat_seen;

    tv[0]  = '{32'sd4736,        19,     1'b0};
    tv[1]  = '{-32'sd4736,       -18,    1'b0};
    tv[2]  = '{32'sd128,         1,      1'b0};
    tv[3]  = '{-32'sd128,        0,      1'b0};
    tv[4]  = '{32'sd384,         2,      1'b0};
    tv[5]  = '{32'sd383,         1,      1'b0};
    tv[6]  = '{32'sh7fffffff,    32767,  1'b1};
    tv[7]  = '{32'sh80000000,    -32768, 1'b1};
    tv[8]  = '{32'sh007fff00,    32767,  1'b0};
    tv[9]  = '{32'sh007fff80,    32767,  1'b1};
    tv[10] = '{-32'sd8388736,    -32768, 1'b0};
    tv[11] = '{-32'sd8388737,    -32768, 1'b1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(v1), 0);
    chk("rst out_data", 32'($signed(d1)), 0);
    chk("rst level", 32'(lvl1), 0);
    chk("rst sat_pulse", 32'(sat1), 0);
    chk("rst drop_sticky", 32'(drop1), 0);
    rst_n = 1'b1;
    tick();

    // Rounding and saturation, one sample at a time through an empty FIFO.
    for (int i = 0; i < 12; i++) begin
      step_in(tv[i].din);
      chk($sformatf("t1[%0d] sat", i), 32'(sat1), 32'(tv[i].exp_sat));
      chk($sformatf("t1[%0d] valid N", i), 32'(v1), 0);
      tick();
      chk($sformatf("t1[%0d] sat N+1", i), 32'(sat1), 0);
      chk($sformatf("t1[%0d] valid N+1", i), 32'(v1), 0);
      tick();
      chk($sformatf("t1[%0d] valid N+2", i), 32'(v1), 1);
      chk($sformatf("t1[%0d] data", i), 32'($signed(d1)), tv[i].exp_q);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk($sformatf("t1[%0d] empty", i), 32'(v1), 0);
    end

    // Decimation by 4: saturating inputs that fall on skipped phases must not pulse.
    do_clr();
    sat_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step_in((k < 9) ? 32'(k << 8) : 32'sh7fffffff);
      sat_seen |= sat4;
    end
    repeat (2) begin
      tick();
      sat_seen |= sat4;
    end
    chk("t3 level", 32'(lvl4), 3);
    chk("t3 no sat on dropped", 32'(sat_seen), 0);
    pop_chk(1'b1, "t3 head0", 0);
    pop_chk(1'b1, "t3 head1", 4);
    pop_chk(1'b1, "t3 head2", 8);
    chk("t3 drained", 32'(v4), 0);

    // Overfill with no consumer, then clear.
    do_clr();
    for (int k = 1; k <= 5; k++) step_in(32'(k << 8));
    repeat (2) tick();
    chk("t4 level full", 32'(lvl1), 4);
    chk("t4 drop_sticky", 32'(drop1), 1);
    for (int k = 1; k <= 4; k++) pop_chk(1'b0, $sformatf("t4 head%0d", k), k);
    chk("t4 level drained", 32'(lvl1), 0);
    step_in(32'sd2560);
    do_clr();
    chk("t4 clr level", 32'(lvl1), 0);
    chk("t4 clr drop", 32'(drop1), 0);
    chk("t4 clr valid", 32'(v1), 0);

    // Full FIFO with a pop on the same edge as the write.
    do_clr();
    for (int k = 1; k <= 4; k++) step_in(32'(k << 8));
    tick();
    chk("t5 level full", 32'(lvl1), 4);
    step_in(32'sd1280);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("t5 level kept", 32'(lvl1), 4);
    chk("t5 no drop", 32'(drop1), 0);
    for (int k = 2; k <= 5; k++) pop_chk(1'b0, $sformatf("t5 head%0d", k), k);

    // Asynchronous reset mid-burst; DECIM=4 phase must restart at 0.
    do_clr();
    step_in(32'sd1792);
    step_in(32'sd2048);
    step_in(32'sd2304);
    repeat (2) tick();
    chk("t6 level before", 32'(lvl1), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 level async", 32'(lvl1), 0);
    chk("t6 valid async", 32'(v1), 0);
    chk("t6 level4 async", 32'(lvl4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    step_in(32'sd1192960);
    chk("t6 valid N", 32'(v4), 0);
    tick();
    chk("t6 valid N+1", 32'(v4), 0);
    tick();
    chk("t6 kept valid", 32'(v4), 1);
    chk("t6 kept data", 32'($signed(d4)), 4660);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
